// File: rtl/mealy_moore_robot_if.sv
// rtl/mealy_moore_robot_if.sv - sensor/command bundle between robot controller and map simulator
interface mealy_moore_robot_if;
  // Sensors: obstacle ahead, wall on left
  logic h;
  logic l;
  // Commands: step forward, rotate 90 degrees right
  logic f_mealy;
  logic r_mealy;
  logic f_moore;
  logic r_moore;

  // Map/simulator side: drives sensors, receives commands
  modport master (
    output h,
    output l,
    input  f_mealy,
    input  r_mealy,
    input  f_moore,
    input  r_moore
  );

  // Controller side: reads sensors, issues commands
  modport slave (
    input  h,
    input  l,
    output f_mealy,
    output r_mealy,
    output f_moore,
    output r_moore
  );
endinterface

// File: rtl/mealy_moore_robot.sv
// rtl/mealy_moore_robot.sv - left-wall-following robot with parallel Mealy and Moore controllers
module mealy_moore_robot #(
  parameter int CLK_FREQ = 7
) (
  input  logic          initial_clk,
  input  logic          rst_n,
  output logic          clk_out,
  mealy_moore_robot_if.slave bus
);

  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  typedef enum logic [2:0] {
    S_SEARCH = 3'd0,
    S_FOLLOW = 3'd1,
    S_ROTATE = 3'd2,
    S_LEFT1  = 3'd3,
    S_LEFT2  = 3'd4,
    S_LEFT3  = 3'd5,
    S_CORNER = 3'd6
  } moore_state_t;

  typedef enum logic [1:0] {
    M_SEARCH = 2'd0,
    M_FOLLOW = 2'd1,
    M_TURN1  = 2'd2,
    M_TURN2  = 2'd3
  } mealy_state_t;

  logic [CW-1:0] count;
  logic          wrap;
  logic          tick;

  moore_state_t  moore_state;
  moore_state_t  moore_next;
  logic          moore_fwd;

  mealy_state_t  mealy_state;
  mealy_state_t  mealy_next;
  logic          mealy_fwd;

  // The tick is the cycle whose closing edge raises clk_out, so both FSMs
  // advance on exactly the edge the external map sees clk_out rise.
  assign wrap = (count == CW'(CLK_FREQ - 1));
  assign tick = wrap & ~clk_out;

  // Divider: count 0..CLK_FREQ-1, toggle clk_out on wrap
  always_ff @(posedge initial_clk) begin
    if (!rst_n) begin
      count   <= '0;
      clk_out <= 1'b0;
    end else if (wrap) begin
      count   <= '0;
      clk_out <= ~clk_out;
    end else begin
      count   <= count + 1'b1;
    end
  end

  // Moore state register, advanced only on tick
  always_ff @(posedge initial_clk) begin
    if (!rst_n) begin
      moore_state <= S_SEARCH;
    end else if (tick) begin
      moore_state <= moore_next;
    end
  end

  // Moore next state from state and sensors; forward decoded from state only
  always_comb begin
    moore_next = moore_state;
    moore_fwd  = 1'b1;
    case (moore_state)
      S_SEARCH: begin
        moore_fwd = 1'b1;
        if (bus.h)      moore_next = S_ROTATE;
        else if (bus.l) moore_next = S_FOLLOW;
        else            moore_next = S_SEARCH;
      end
      S_FOLLOW: begin
        moore_fwd = 1'b1;
        if (bus.h)      moore_next = S_ROTATE;
        else if (bus.l) moore_next = S_FOLLOW;
        else            moore_next = S_LEFT1;
      end
      S_ROTATE: begin
        moore_fwd = 1'b0;
        if (bus.h)      moore_next = S_ROTATE;
        else if (bus.l) moore_next = S_FOLLOW;
        else            moore_next = S_SEARCH;
      end
      // Three right turns make the left turn around the lost wall's corner
      S_LEFT1: begin
        moore_fwd  = 1'b0;
        moore_next = S_LEFT2;
      end
      S_LEFT2: begin
        moore_fwd  = 1'b0;
        moore_next = S_LEFT3;
      end
      S_LEFT3: begin
        moore_fwd  = 1'b0;
        moore_next = S_CORNER;
      end
      // Step past the corner before re-acquiring the wall
      S_CORNER: begin
        moore_fwd = 1'b1;
        if (bus.h)      moore_next = S_ROTATE;
        else if (bus.l) moore_next = S_FOLLOW;
        else            moore_next = S_SEARCH;
      end
      // Unused encoding: behave as search and recover on the next tick
      default: begin
        moore_fwd  = 1'b1;
        moore_next = S_SEARCH;
      end
    endcase
  end

  // Mealy state register, advanced only on tick
  always_ff @(posedge initial_clk) begin
    if (!rst_n) begin
      mealy_state <= M_SEARCH;
    end else if (tick) begin
      mealy_state <= mealy_next;
    end
  end

  // Mealy next state and command from state plus live sensors
  always_comb begin
    mealy_next = mealy_state;
    mealy_fwd  = 1'b1;
    case (mealy_state)
      M_SEARCH: begin
        if (bus.h) begin
          mealy_fwd  = 1'b0;
          mealy_next = M_FOLLOW;
        end else begin
          mealy_fwd  = 1'b1;
          mealy_next = bus.l ? M_FOLLOW : M_SEARCH;
        end
      end
      M_FOLLOW: begin
        if (bus.h) begin
          mealy_fwd  = 1'b0;
          mealy_next = M_FOLLOW;
        end else if (bus.l) begin
          mealy_fwd  = 1'b1;
          mealy_next = M_FOLLOW;
        end else begin
          // Wall lost: first of three right turns
          mealy_fwd  = 1'b0;
          mealy_next = M_TURN1;
        end
      end
      M_TURN1: begin
        mealy_fwd  = 1'b0;
        mealy_next = M_TURN2;
      end
      M_TURN2: begin
        mealy_fwd  = 1'b0;
        mealy_next = M_SEARCH;
      end
      default: begin
        mealy_fwd  = 1'b1;
        mealy_next = M_SEARCH;
      end
    endcase
  end

  // Commands are one-hot out of reset and all low while reset is held
  assign bus.f_moore = rst_n &  moore_fwd;
  assign bus.r_moore = rst_n & ~moore_fwd;
  assign bus.f_mealy = rst_n &  mealy_fwd;
  assign bus.r_mealy = rst_n & ~mealy_fwd;

endmodule

// File: tb/tb_mealy_moore_robot.sv
// tb/tb_mealy_moore_robot.sv - self-checking bench for mealy_moore_robot
module tb_mealy_moore_robot;

  localparam int CLK_FREQ = 7;

  // Reference-model state numbering (independent of the RTL encoding)
  localparam int A_SEARCH = 0, A_FOLLOW = 1, A_TURN1 = 2, A_TURN2 = 3;
  localparam int B_SEARCH = 0, B_FOLLOW = 1, B_ROTATE = 2, B_LEFT1 = 3,
                 B_LEFT2 = 4, B_LEFT3 = 5, B_CORNER = 6;

  logic initial_clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_out;

  mealy_moore_robot_if bus ();

  mealy_moore_robot #(.CLK_FREQ(CLK_FREQ)) dut (
    .initial_clk(initial_clk),
    .rst_n      (rst_n),
    .clk_out    (clk_out),
    .bus        (bus)
  );

  always #5 initial_clk = ~initial_clk;

  int tests_run = 0;
  int tests_failed = 0;

  int me_nxt [4][4];
  bit me_fwd [4][4];
  int mo_nxt [7][4];
  bit mo_fwd [7];

  int me_st = A_SEARCH;
  int mo_st = B_SEARCH;
  bit cur_h = 1'b0;
  bit cur_l = 1'b0;

  // Build transition/command tables straight from the behavioural rules
  function automatic void build_models();
    bit hh;
    bit ll;
    for (int i = 0; i < 4; i++) begin
      hh = i[1];
      ll = i[0];
      me_fwd[A_SEARCH][i] = !hh;
      me_nxt[A_SEARCH][i] = (hh || ll) ? A_FOLLOW : A_SEARCH;
      me_fwd[A_FOLLOW][i] = !hh && ll;
      me_nxt[A_FOLLOW][i] = (hh || ll) ? A_FOLLOW : A_TURN1;
      me_fwd[A_TURN1][i]  = 1'b0;
      me_nxt[A_TURN1][i]  = A_TURN2;
      me_fwd[A_TURN2][i]  = 1'b0;
      me_nxt[A_TURN2][i]  = A_SEARCH;

      mo_nxt[B_SEARCH][i] = hh ? B_ROTATE : (ll ? B_FOLLOW : B_SEARCH);
      mo_nxt[B_FOLLOW][i] = hh ? B_ROTATE : (ll ? B_FOLLOW : B_LEFT1);
      mo_nxt[B_ROTATE][i] = hh ? B_ROTATE : (ll ? B_FOLLOW : B_SEARCH);
      mo_nxt[B_LEFT1][i]  = B_LEFT2;
      mo_nxt[B_LEFT2][i]  = B_LEFT3;
      mo_nxt[B_LEFT3][i]  = B_CORNER;
      mo_nxt[B_CORNER][i] = hh ? B_ROTATE : (ll ? B_FOLLOW : B_SEARCH);
    end
    mo_fwd[B_SEARCH] = 1'b1;
    mo_fwd[B_FOLLOW] = 1'b1;
    mo_fwd[B_ROTATE] = 1'b0;
    mo_fwd[B_LEFT1]  = 1'b0;
    mo_fwd[B_LEFT2]  = 1'b0;
    mo_fwd[B_LEFT3]  = 1'b0;
    mo_fwd[B_CORNER] = 1'b1;
  endfunction

  // Wait for the next clk_out rise, advance the models with the held sensors,
  // then present new sensor values the way the map would
  task automatic step(input bit nh, input bit nl);
    bit prev;
    bit seen;
    seen = 1'b0;
    prev = clk_out;
    for (int n = 0; n < 2 * CLK_FREQ + 4; n++) begin
      @(posedge initial_clk);
      #1;
      if (clk_out === 1'b1 && prev === 1'b0) begin
        seen = 1'b1;
        break;
      end
      prev = clk_out;
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL tick_timeout: clk_out rise not seen within %0d cycles", 2 * CLK_FREQ + 4);
    end
    me_st = me_nxt[me_st][{cur_h, cur_l}];
    mo_st = mo_nxt[mo_st][{cur_h, cur_l}];
    cur_h = nh;
    cur_l = nl;
    bus.h = nh;
    bus.l = nl;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.h = 1'b0;
    bus.l = 1'b0;
    cur_h = 1'b0;
    cur_l = 1'b0;
    repeat (3) @(posedge initial_clk);
    #1;
    tests_run++;
    if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore, clk_out} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got fm,rm,fo,ro,clk_out=%b required 00000",
               {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore, clk_out});
    end
    rst_n = 1'b1;
    me_st = A_SEARCH;
    mo_st = B_SEARCH;
    #1;
    tests_run++;
    if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_release: got fm,rm,fo,ro=%b required 1010",
               {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore});
    end
  endtask

  // Called right after reset release (just past an edge)
  task automatic test_divider();
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge initial_clk);
      n++;
      #1;
      if (clk_out === 1'b1) break;
    end
    tests_run++;
    if (n != CLK_FREQ) begin
      tests_failed++;
      $display("FAIL divider_first_rise: got %0d cycles required %0d", n, CLK_FREQ);
    end
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge initial_clk);
      n++;
      #1;
      if (clk_out === 1'b0) break;
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge initial_clk);
      n++;
      #1;
      if (clk_out === 1'b1) break;
    end
    tests_run++;
    if (n != 2 * CLK_FREQ) begin
      tests_failed++;
      $display("FAIL divider_period: got %0d cycles required %0d", n, 2 * CLK_FREQ);
    end
  endtask

  task automatic test_search();
    for (int t = 0; t < 5; t++) begin
      step(1'b0, 1'b0);
      tests_run++;
      if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore} !== 4'b1010) begin
        tests_failed++;
        $display("FAIL search_tick%0d: got fm,rm,fo,ro=%b required 1010", t,
                 {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore});
      end
    end
  endtask

  task automatic test_obstacle();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    tests_run++;
    if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL obstacle_follow: got %b required 1010",
               {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore});
    end
    step(1'b1, 1'b0);
    tests_run++;
    if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL obstacle_same_tick: got %b required 0110",
               {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore});
    end
    step(1'b1, 1'b0);
    tests_run++;
    if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL obstacle_next_tick: got %b required 0101",
               {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore});
    end
    step(1'b0, 1'b1);
    tests_run++;
    if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL obstacle_clear_mealy: got %b required 1001",
               {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore});
    end
    step(1'b0, 1'b1);
    tests_run++;
    if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL obstacle_clear_both: got %b required 1010",
               {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore});
    end
  endtask

  // Both controllers are in follow with l=1 held on entry
  task automatic test_lost_wall();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0110;
    exp_seq[1] = 4'b0101;
    exp_seq[2] = 4'b0101;
    exp_seq[3] = 4'b1001;
    exp_seq[4] = 4'b1010;
    for (int t = 0; t < 5; t++) begin
      step(1'b0, 1'b0);
      tests_run++;
      if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore} !== exp_seq[t]) begin
        tests_failed++;
        $display("FAIL lost_wall_tick%0d: got %b required %b", t,
                 {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore}, exp_seq[t]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    tests_run++;
    if (bus.r_moore !== 1'b1 || mo_st != B_LEFT2) begin
      tests_failed++;
      $display("FAIL midrun_in_left2: got r_moore=%b required 1", bus.r_moore);
    end
    #2;
    rst_n = 1'b0;
    @(posedge initial_clk);
    #1;
    tests_run++;
    if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore, clk_out} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL midrun_reset_outputs: got %b required 00000",
               {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore, clk_out});
    end
    @(posedge initial_clk);
    #1;
    bus.h = 1'b0;
    bus.l = 1'b0;
    cur_h = 1'b0;
    cur_l = 1'b0;
    me_st = A_SEARCH;
    mo_st = B_SEARCH;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({bus.f_moore, bus.r_moore} !== 2'b10) begin
      tests_failed++;
      $display("FAIL midrun_release_moore: got fo,ro=%b required 10", {bus.f_moore, bus.r_moore});
    end
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge initial_clk);
      n++;
      #1;
      if (clk_out === 1'b1) break;
    end
    tests_run++;
    if (n != CLK_FREQ) begin
      tests_failed++;
      $display("FAIL midrun_first_tick: got %0d cycles required %0d", n, CLK_FREQ);
    end
  endtask

  task automatic test_random();
    bit ef;
    bit mf;
    int bad_model;
    int bad_excl;
    bad_model = 0;
    bad_excl = 0;
    for (int t = 0; t < 1000; t++) begin
      step(1'($urandom), 1'($urandom));
      ef = me_fwd[me_st][{cur_h, cur_l}];
      mf = mo_fwd[mo_st];
      tests_run++;
      if ({bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore} !== {ef, !ef, mf, !mf}) begin
        tests_failed++;
        bad_model++;
        if (bad_model <= 5)
          $display("FAIL random_model tick%0d h=%b l=%b: got %b required %b", t, cur_h, cur_l,
                   {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore}, {ef, !ef, mf, !mf});
      end
      tests_run++;
      if ((bus.f_mealy & bus.r_mealy) !== 1'b0 || (bus.f_moore & bus.r_moore) !== 1'b0) begin
        tests_failed++;
        bad_excl++;
        if (bad_excl <= 5)
          $display("FAIL random_exclusive tick%0d: got fm,rm,fo,ro=%b required no f=r=1", t,
                   {bus.f_mealy, bus.r_mealy, bus.f_moore, bus.r_moore});
      end
    end
  endtask

  initial begin
    build_models();
    test_reset();
    test_divider();
    test_search();
    test_obstacle();
    test_lost_wall();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
